ste_level_detect: RTL

//  Downstream consumer of the short-term RMS stage. Takes each RMS result (rms_i + rms_update_i).

---
 rtl/ste_level_detect.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ste_level_detect.sv
// Debounced activity detector fed by the short-term RMS stage: hysteresis thresholds,
// attack qualification, hangover, episode counting and per-episode peak capture.
module ste_level_detect #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned EVT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic [DATA_W-1:0] rms_i,
   input  logic              rms_update_i,
   input  logic [DATA_W-1:0] thr_on_i,
   input  logic [DATA_W-1:0] thr_off_i,
   input  logic [CNT_W-1:0]  attack_len_i,
   input  logic [CNT_W-1:0]  hold_len_i,
   output logic              active_o,
   output logic              event_o,
   output logic [DATA_W-1:0] peak_o,
   output logic              peak_valid_o,
   output logic [EVT_W-1:0]  episodes_o
);

   typedef enum logic [1:0] {StSilent, StAttack, StActive, StHangover} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] peak_run_q, peak_run_d;
   logic [DATA_W-1:0] peak_q, peak_d;
   logic              event_q, event_d;
   logic              peak_valid_q, peak_valid_d;
   logic [EVT_W-1:0]  episodes_q, episodes_d;

   logic [DATA_W-1:0] thr_off_eff;
   logic [DATA_W-1:0] peak_max;
   logic [CNT_W-1:0]  attack_eff, hold_eff, cnt_inc;
   logic [EVT_W-1:0]  episodes_inc;
   logic              above_on, below_off;

   // Release threshold never sits above the activation threshold.
   assign thr_off_eff  = (thr_off_i < thr_on_i) ? thr_off_i : thr_on_i;
   assign attack_eff   = (attack_len_i == '0) ? CNT_W'(1) : attack_len_i;
   assign hold_eff     = (hold_len_i == '0) ? CNT_W'(1) : hold_len_i;
   assign above_on     = (rms_i >= thr_on_i);
   assign below_off    = (rms_i < thr_off_eff);
   assign peak_max     = (rms_i > peak_run_q) ? rms_i : peak_run_q;
   assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   assign episodes_inc = (&episodes_q) ? episodes_q : episodes_q + EVT_W'(1);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      peak_run_d   = peak_run_q;
      peak_d       = peak_q;
      event_d      = 1'b0;
      peak_valid_d = 1'b0;
      episodes_d   = episodes_q;
      if (rms_update_i) begin
         case (state_q)
            StSilent: begin
               if (above_on) begin
                  peak_run_d = rms_i;
                  if (attack_eff == CNT_W'(1)) begin
                     state_d    = StActive;
                     cnt_d      = '0;
                     event_d    = 1'b1;
                     episodes_d = episodes_inc;
                  end else begin
                     state_d = StAttack;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            StAttack: begin
               if (above_on) begin
                  peak_run_d = peak_max;
                  cnt_d      = cnt_inc;
                  if (cnt_inc >= attack_eff) begin
                     state_d    = StActive;
                     cnt_d      = '0;
                     event_d    = 1'b1;
                     episodes_d = episodes_inc;
                  end
               end else begin
                  state_d    = StSilent;
                  cnt_d      = '0;
                  peak_run_d = '0;
               end
            end
            StActive: begin
               peak_run_d = peak_max;
               if (below_off) begin
                  if (hold_eff == CNT_W'(1)) begin
                     state_d      = StSilent;
                     cnt_d        = '0;
                     event_d      = 1'b1;
                     peak_d       = peak_max;
                     peak_valid_d = 1'b1;
                     peak_run_d   = '0;
                  end else begin
                     state_d = StHangover;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            StHangover: begin
               peak_run_d = peak_max;
               if (!below_off) begin
                  state_d = StActive;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= hold_eff) begin
                     state_d      = StSilent;
                     cnt_d        = '0;
                     event_d      = 1'b1;
                     peak_d       = peak_max;
                     peak_valid_d = 1'b1;
                     peak_run_d   = '0;
                  end
               end
            end
            default: state_d = StSilent;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StSilent;
         cnt_q        <= '0;
         peak_run_q   <= '0;
         peak_q       <= '0;
         event_q      <= 1'b0;
         peak_valid_q <= 1'b0;
         episodes_q   <= '0;
      end else if (clr_i) begin
         state_q      <= StSilent;
         cnt_q        <= '0;
         peak_run_q   <= '0;
         peak_q       <= '0;
         event_q      <= 1'b0;
         peak_valid_q <= 1'b0;
         episodes_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         peak_run_q   <= peak_run_d;
         peak_q       <= peak_d;
         event_q      <= event_d;
         peak_valid_q <= peak_valid_d;
         episodes_q   <= episodes_d;
      end
   end

   assign active_o     = (state_q == StActive) || (state_q == StHangover);
   assign event_o      = event_q;
   assign peak_o       = peak_q;
   assign peak_valid_o = peak_valid_q;
   assign episodes_o   = episodes_q;

endmodule
